// File: rtl/demux1x8_tdm.sv
// demux1x8_tdm: 1-to-8 TDM demux; auto mode builds 8-word frames, direct mode steers words by S2..S0.
// Latency: direct write lands on Y one cycle later; a completed frame shows on Y the cycle after its 8th word.
// Backpressure: none on din; a completed frame is dropped (sticky overrun) if the held one is unacked. Option: DEMUX_TIMEOUT_EN.
module demux1x8_tdm #(
    parameter int WIDTH   = 1,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             auto,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic             frame_ack,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y4,
    output logic [WIDTH-1:0] Y5,
    output logic [WIDTH-1:0] Y6,
    output logic [WIDTH-1:0] Y7,
    output logic             frame_valid,
    output logic [2:0]       lane_ptr,
`ifdef DEMUX_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             overrun
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("demux1x8_tdm: TIMEOUT must be in 2..255");
    end

    logic [WIDTH-1:0] y_q        [8];
    logic [WIDTH-1:0] shadow     [8];
    logic [WIDTH-1:0] frame_next [8];
    logic [2:0]       sel;
    logic             complete;
    logic             publish;
    logic             drop;
    logic             tmo_hit;

    assign sel      = {S2, S1, S0};
    assign complete = auto & din_valid & (lane_ptr == 3'd7);
    assign publish  = complete & (~frame_valid | frame_ack);
    assign drop     = complete & frame_valid & ~frame_ack;

    // The 8th word is merged here so it reaches Y on the same edge it is accepted.
    always_comb begin
        frame_next = shadow;
        frame_next[lane_ptr] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_ptr    <= 3'd0;
            frame_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                y_q[i]    <= '0;
                shadow[i] <= '0;
            end
        end else if (!auto) begin
            // Direct mode also covers the 1->0 switch: partial frame and pending frame are discarded.
            lane_ptr    <= 3'd0;
            frame_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
            end
            if (din_valid) begin
                y_q[sel] <= din;
            end
        end else begin
            if (tmo_hit) begin
                lane_ptr <= 3'd0;
                for (int i = 0; i < 8; i++) begin
                    shadow[i] <= '0;
                end
            end else if (din_valid) begin
                shadow[lane_ptr] <= din;
                lane_ptr         <= 3'(lane_ptr + 3'd1);
            end

            if (publish) begin
                y_q         <= frame_next;
                frame_valid <= 1'b1;
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // A fresh drop takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

`ifdef DEMUX_TIMEOUT_EN
    logic [7:0] idle_cnt;

    assign tmo_hit = auto & ~din_valid & (lane_ptr != 3'd0) & (idle_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (!auto || din_valid || lane_ptr == 3'd0 || tmo_hit) begin
                idle_cnt <= 8'd0;
            end else begin
                idle_cnt <= 8'(idle_cnt + 8'd1);
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign Y0 = y_q[0];
    assign Y1 = y_q[1];
    assign Y2 = y_q[2];
    assign Y3 = y_q[3];
    assign Y4 = y_q[4];
    assign Y5 = y_q[5];
    assign Y6 = y_q[6];
    assign Y7 = y_q[7];

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Directed bench for demux1x8_tdm (WIDTH=1): expected lane/flag snapshots are queued per step and popped after the edge.
module tb_demux1x8_tdm;

    typedef struct packed {
        logic [7:0] y;
        logic       fv;
        logic [2:0] ptr;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] din = 1'b0;
    logic       din_valid = 1'b0;
    logic       auto = 1'b0;
    logic       S0 = 1'b0, S1 = 1'b0, S2 = 1'b0;
    logic       frame_ack = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [0:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic       frame_valid;
    logic [2:0] lane_ptr;
    logic       overrun;
`ifdef DEMUX_TIMEOUT_EN
    logic       timeout_err;
`endif
    logic [7:0] yv;

    exp_t  sb[$];
    string tags[$];
    int    passed = 0;
    int    failed = 0;
    int    total  = 0;

    assign yv = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

    demux1x8_tdm #(.WIDTH(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .auto(auto),
        .S0(S0), .S1(S1), .S2(S2), .frame_ack(frame_ack), .clr_ovr(clr_ovr),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
        .frame_valid(frame_valid), .lane_ptr(lane_ptr),
`ifdef DEMUX_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string tag;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e   = sb.pop_front();
        tag = tags.pop_front();
        total++;
        assert (yv === e.y) passed++;
        else begin failed++; $error("FAIL %s.y: got %h expected %h", tag, yv, e.y); end
        total++;
        assert (frame_valid === e.fv) passed++;
        else begin failed++; $error("FAIL %s.frame_valid: got %b expected %b", tag, frame_valid, e.fv); end
        total++;
        assert (lane_ptr === e.ptr) passed++;
        else begin failed++; $error("FAIL %s.lane_ptr: got %0d expected %0d", tag, lane_ptr, e.ptr); end
        total++;
        assert (overrun === e.ovr) passed++;
        else begin failed++; $error("FAIL %s.overrun: got %b expected %b", tag, overrun, e.ovr); end
    endtask

    // Push the expectation for the inputs now on the pins, clock once, then compare.
    task automatic run(input string tag, input logic [7:0] y, input logic fv,
                       input logic [2:0] ptr, input logic ovr);
        exp_t e;
        e = '{y: y, fv: fv, ptr: ptr, ovr: ovr};
        sb.push_back(e);
        tags.push_back(tag);
        step();
        check_out();
    endtask

    task automatic push_words(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            din       = bits[i];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
    endtask

    // Lane i of the frame receives bits[i]; ack is applied together with the 8th word.
    task automatic send_frame(input string tag, input logic [7:0] bits, input logic ack,
                              input logic [7:0] ey, input logic efv, input logic eovr);
        push_words(bits, 7);
        din       = bits[7];
        din_valid = 1'b1;
        frame_ack = ack;
        run(tag, ey, efv, 3'd0, eovr);
        din_valid = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic direct(input string tag, input logic [2:0] s, input logic d, input logic v,
                          input logic [7:0] ey);
        {S2, S1, S0} = s;
        din          = d;
        din_valid    = v;
        run(tag, ey, 1'b0, 3'd0, 1'b0);
        din_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        rst  = 1'b0;
        auto = 1'b1;

        // Y0..Y7 = 1,0,1,1,0,0,1,0
        send_frame("frame_a", 8'h4D, 1'b0, 8'h4D, 1'b1, 1'b0);
        send_frame("overrun_drop", 8'hA5, 1'b0, 8'h4D, 1'b1, 1'b1);
        clr_ovr = 1'b1;
        run("clr_ovr", 8'h4D, 1'b1, 3'd0, 1'b0);
        clr_ovr = 1'b0;
        send_frame("ack_with_complete", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
        frame_ack = 1'b1;
        run("ack_release", 8'h3C, 1'b0, 3'd0, 1'b0);
        frame_ack = 1'b0;

        auto = 1'b0;
        direct("direct_s5_d0", 3'd5, 1'b0, 1'b1, 8'h1C);
        direct("direct_s5_d1", 3'd5, 1'b1, 1'b1, 8'h3C);
        direct("direct_s0_d1", 3'd0, 1'b1, 1'b1, 8'h3D);
        direct("direct_s0_d0", 3'd0, 1'b0, 1'b1, 8'h3C);
        direct("direct_novalid", 3'd3, 1'b1, 1'b0, 8'h3C);

        auto = 1'b1;
        push_words(8'hFF, 2);
        din       = 1'b1;
        din_valid = 1'b1;
        run("partial_3", 8'h3C, 1'b0, 3'd3, 1'b0);
        din_valid = 1'b0;
        auto      = 1'b0;
        run("mode_switch", 8'h3C, 1'b0, 3'd0, 1'b0);
        auto = 1'b1;
        send_frame("clean_after_switch", 8'h81, 1'b0, 8'h81, 1'b1, 1'b0);
        send_frame("overrun_again", 8'h5A, 1'b0, 8'h81, 1'b1, 1'b1);

        push_words(8'hFF, 3);
        rst = 1'b1;
        run("reset_mid_frame", 8'h00, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        send_frame("frame_after_reset", 8'hF0, 1'b0, 8'hF0, 1'b1, 1'b0);
        clr_ovr = 1'b1;
        send_frame("set_beats_clear", 8'h0F, 1'b0, 8'hF0, 1'b1, 1'b1);
        clr_ovr   = 1'b0;
        frame_ack = 1'b1;
        run("ack_release_2", 8'hF0, 1'b0, 3'd0, 1'b1);
        frame_ack = 1'b0;

`ifdef DEMUX_TIMEOUT_EN
        push_words(8'hFF, 3);
        for (int i = 1; i <= 15; i++) begin
            step();
            check_bit("timeout_idle", timeout_err, 1'b0);
            check_bit("timeout_ptr_held", lane_ptr == 3'd3, 1'b1);
        end
        run("timeout_fire", 8'hF0, 1'b0, 3'd0, 1'b1);
        check_bit("timeout_pulse", timeout_err, 1'b1);
        step();
        check_bit("timeout_pulse_end", timeout_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
